lru_cache: RTL

- Set-associative, write-back, write-allocate data cache.
- Responder to the WB-stage memory access port: the pipeline drives addr/rd_req/wr_req/wr_data and stalls while miss is high.
- On its back side it is the initiator to a line-wide main-memory model through a request/grant handshake.
- Replacement policy is selectable between LRU and FIFO.

---
 rtl/lru_cache.sv | 318 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/lru_cache.sv
// -----------------------------------------------------------------------------
// lru_cache
// Set-associative, write-back, write-allocate data cache sitting on the WB-stage
// memory access port, with a line-wide request/grant interface to main memory.
//
// Build option:
//   CACHE_LRU_EN  defined   -> LRU replacement (per-way age counters, hits age)
//                 undefined -> FIFO replacement (per-set round-robin pointer,
//                              advanced on fills only; no age counters built)
//
// Ports:
//   clk          in   clock, rising-edge
//   rst_n        in   asynchronous active-low reset
//   addr         in   byte address (word / set / tag fields, [1:0] ignored)
//   rd_req       in   load request
//   wr_req       in   store request (full word)
//   wr_data      in   store data
//   rd_data      out  load data, combinational on hit
//   miss         out  request not yet serviced (pipeline stalls while high)
//   mem_addr     out  line address {tag, set} to memory
//   mem_rd_req   out  line fill request
//   mem_wr_req   out  line write-back request
//   mem_wr_line  out  victim line data
//   mem_rd_line  in   fill data, valid with mem_gnt during a read
//   mem_gnt      in   one-cycle pulse completing the current transfer
//
// state      | meaning
// -----------+--------------------------------------------------------------
// IDLE       | serving hits; a miss picks a victim and leaves this state
// SWAP_OUT   | writing the dirty victim line back, waiting for mem_gnt
// SWAP_IN    | fetching the requested line, waiting for mem_gnt
// SWAP_IN_OK | installing the fetched line into the victim way
// -----------------------------------------------------------------------------
module lru_cache #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int SET_ADDR_LEN  = 2,
    parameter int TAG_ADDR_LEN  = 8,
    parameter int WAY_CNT       = 4
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [31:0]                            addr,
    input  logic                                   rd_req,
    input  logic                                   wr_req,
    input  logic [31:0]                            wr_data,
    output logic [31:0]                            rd_data,
    output logic                                   miss,
    output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0]   mem_addr,
    output logic                                   mem_rd_req,
    output logic                                   mem_wr_req,
    output logic [32*(1<<LINE_ADDR_LEN)-1:0]       mem_wr_line,
    input  logic [32*(1<<LINE_ADDR_LEN)-1:0]       mem_rd_line,
    input  logic                                   mem_gnt
);

    localparam int LINE_WORDS = 1 << LINE_ADDR_LEN;
    localparam int SET_CNT    = 1 << SET_ADDR_LEN;
    localparam int LINE_W     = 32 * LINE_WORDS;
    localparam int WAY_W      = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
    localparam int ADDR_USED  = LINE_ADDR_LEN + 2 + SET_ADDR_LEN + TAG_ADDR_LEN;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        SWAP_OUT   = 2'd1,
        SWAP_IN    = 2'd2,
        SWAP_IN_OK = 2'd3
    } state_t;

    state_t r_state, w_state_nxt;

    // storage
    logic [31:0]             r_data  [SET_CNT][WAY_CNT][LINE_WORDS];
    logic [TAG_ADDR_LEN-1:0] r_tag   [SET_CNT][WAY_CNT];
    logic [WAY_CNT-1:0]      r_valid [SET_CNT];
    logic [WAY_CNT-1:0]      r_dirty [SET_CNT];
    logic [LINE_W-1:0]       r_fill_line;

    // miss context captured when leaving IDLE
    logic [TAG_ADDR_LEN-1:0] r_req_tag;
    logic [SET_ADDR_LEN-1:0] r_req_set;
    logic [WAY_W-1:0]        r_victim;

    // address decode
    logic [LINE_ADDR_LEN-1:0] w_word;
    logic [SET_ADDR_LEN-1:0]  w_set;
    logic [TAG_ADDR_LEN-1:0]  w_tag;
    logic                     w_unused_addr;

    assign w_word = addr[LINE_ADDR_LEN+1:2];
    assign w_set  = addr[LINE_ADDR_LEN+2 +: SET_ADDR_LEN];
    assign w_tag  = addr[LINE_ADDR_LEN+2+SET_ADDR_LEN +: TAG_ADDR_LEN];
    assign w_unused_addr = ^{addr[1:0], addr[31:ADDR_USED]};

    logic w_req;
    logic w_hit;
    logic [WAY_W-1:0] w_hit_way;
    logic w_idle_hit;
    logic w_idle_miss;

    assign w_req = rd_req | wr_req;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int i = 0; i < WAY_CNT; i++) begin
            if (!w_hit && r_valid[w_set][i] && (r_tag[w_set][i] == w_tag)) begin
                w_hit     = 1'b1;
                w_hit_way = WAY_W'(i);
            end
        end
    end

    assign w_idle_hit  = (r_state == IDLE) && w_req && w_hit;
    assign w_idle_miss = (r_state == IDLE) && w_req && !w_hit;

    // victim selection: an empty way always wins over the policy choice
    logic             w_inv_found;
    logic [WAY_W-1:0] w_inv_way;
    logic [WAY_W-1:0] w_pol_way;
    logic [WAY_W-1:0] w_victim;

    always_comb begin
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int i = 0; i < WAY_CNT; i++) begin
            if (!w_inv_found && !r_valid[w_set][i]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(i);
            end
        end
    end

    assign w_victim = w_inv_found ? w_inv_way : w_pol_way;

`ifdef CACHE_LRU_EN
    // Age 0 = most recent. On an access the ways younger than the touched
    // way get one older; a fill into an empty way ages every other way.
    logic [WAY_W-1:0]        r_age [SET_CNT][WAY_CNT];
    logic                    w_upd_en;
    logic [SET_ADDR_LEN-1:0] w_upd_set;
    logic [WAY_W-1:0]        w_upd_way;
    logic [WAY_W-1:0]        w_upd_ref;
    logic [WAY_W-1:0]        w_old_age;

    always_comb begin
        w_upd_en  = 1'b0;
        w_upd_set = w_set;
        w_upd_way = w_hit_way;
        w_upd_ref = r_age[w_set][w_hit_way];
        if (r_state == SWAP_IN_OK) begin
            w_upd_en  = 1'b1;
            w_upd_set = r_req_set;
            w_upd_way = r_victim;
            w_upd_ref = r_valid[r_req_set][r_victim] ? r_age[r_req_set][r_victim] : '1;
        end else if (w_idle_hit) begin
            w_upd_en  = 1'b1;
        end
    end

    always_comb begin
        w_pol_way = '0;
        w_old_age = r_age[w_set][0];
        for (int i = 1; i < WAY_CNT; i++) begin
            if (r_age[w_set][i] > w_old_age) begin
                w_old_age = r_age[w_set][i];
                w_pol_way = WAY_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SET_CNT; s++) begin
                for (int i = 0; i < WAY_CNT; i++) begin
                    r_age[s][i] <= '0;
                end
            end
        end else if (w_upd_en) begin
            for (int i = 0; i < WAY_CNT; i++) begin
                if (WAY_W'(i) == w_upd_way) begin
                    r_age[w_upd_set][i] <= '0;
                end else if (r_age[w_upd_set][i] < w_upd_ref) begin
                    r_age[w_upd_set][i] <= r_age[w_upd_set][i] + 1'b1;
                end
            end
        end
    end
`else
    // Round-robin pointer; moves to the way after the one just filled.
    logic [WAY_W-1:0] r_ptr [SET_CNT];

    assign w_pol_way = r_ptr[w_set];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SET_CNT; s++) begin
                r_ptr[s] <= '0;
            end
        end else if (r_state == SWAP_IN_OK) begin
            r_ptr[r_req_set] <= (r_victim == WAY_W'(WAY_CNT - 1)) ? '0 : r_victim + 1'b1;
        end
    end
`endif

    // FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_idle_miss) begin
                    if (r_valid[w_set][w_victim] && r_dirty[w_set][w_victim]) begin
                        w_state_nxt = SWAP_OUT;
                    end else begin
                        w_state_nxt = SWAP_IN;
                    end
                end
            end
            SWAP_OUT: begin
                if (mem_gnt) w_state_nxt = SWAP_IN;
            end
            SWAP_IN: begin
                if (mem_gnt) w_state_nxt = SWAP_IN_OK;
            end
            SWAP_IN_OK: begin
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_tag <= '0;
            r_req_set <= '0;
            r_victim  <= '0;
        end else if (w_idle_miss) begin
            r_req_tag <= w_tag;
            r_req_set <= w_set;
            r_victim  <= w_victim;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SET_CNT; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
            end
        end else begin
            if (w_idle_hit && wr_req) begin
                r_dirty[w_set][w_hit_way] <= 1'b1;
            end
            if (r_state == SWAP_IN_OK) begin
                r_valid[r_req_set][r_victim] <= 1'b1;
                r_dirty[r_req_set][r_victim] <= 1'b0;
            end
        end
    end

    // data and tag arrays are not reset; valid bits guard them
    always_ff @(posedge clk) begin
        if (w_idle_hit && wr_req) begin
            r_data[w_set][w_hit_way][w_word] <= wr_data;
        end
        if ((r_state == SWAP_IN) && mem_gnt) begin
            r_fill_line <= mem_rd_line;
        end
        if (r_state == SWAP_IN_OK) begin
            r_tag[r_req_set][r_victim] <= r_req_tag;
            for (int w = 0; w < LINE_WORDS; w++) begin
                r_data[r_req_set][r_victim][w] <= r_fill_line[32*w +: 32];
            end
        end
    end

    // outputs
    logic [LINE_W-1:0] w_victim_line;

    always_comb begin
        w_victim_line = '0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            w_victim_line[32*w +: 32] = r_data[r_req_set][r_victim][w];
        end
    end

    // miss is forced low in reset even if the pipeline still holds a request
    assign miss       = rst_n & ((r_state != IDLE) | (w_req & ~w_hit));
    assign rd_data    = ((r_state == IDLE) && w_hit) ? r_data[w_set][w_hit_way][w_word] : 32'd0;
    assign mem_wr_req = (r_state == SWAP_OUT);
    assign mem_rd_req = (r_state == SWAP_IN);

    always_comb begin
        mem_addr    = '0;
        mem_wr_line = '0;
        case (r_state)
            SWAP_OUT: begin
                mem_addr    = {r_tag[r_req_set][r_victim], r_req_set};
                mem_wr_line = w_victim_line;
            end
            SWAP_IN: begin
                mem_addr    = {r_req_tag, r_req_set};
            end
            default: begin
                mem_addr    = '0;
                mem_wr_line = '0;
            end
        endcase
    end

endmodule
